// File: rtl/i2s_tx_fifo.sv
// Stereo sample FIFO in the I2S clock domain: valid/ready write side, rd_en/rd_valid read side,
// with priming before playback and zero-fill plus counted underruns when starved.
module i2s_tx_fifo #(
   parameter int unsigned DW        = 24,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned START_LVL = 8,
   parameter int unsigned LW        = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] s_ldata,
   input  logic [DW-1:0] s_rdata,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic          rd_en,
   output logic [DW-1:0] ldata,
   output logic [DW-1:0] rdata,
   output logic          rd_valid,
   output logic [LW-1:0] level,
   output logic          running,
   output logic          underrun,
   output logic [15:0]   underrun_cnt,
   input  logic          clr_underrun
);

   localparam int unsigned AW = LW - 1;

   typedef enum logic [0:0] {StPrime, StRun} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [2*DW-1:0] r_mem [DEPTH];
   logic [LW-1:0]   r_wr_ptr;
   logic [LW-1:0]   r_rd_ptr;
   logic [LW-1:0]   w_level;
   logic            w_wr;
   logic            w_pop;
   logic            w_underrun;
   logic            r_rd_valid;
   logic [DW-1:0]   r_ldata;
   logic [DW-1:0]   r_rdata;
   logic            r_underrun;
   logic [15:0]     r_underrun_cnt;

   // Pointers carry one extra wrap bit so their difference spans 0..DEPTH.
   assign w_level = r_wr_ptr - r_rd_ptr;
   assign s_ready = (w_level != LW'(DEPTH));
   assign w_wr    = s_valid && s_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StPrime;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_underrun  = 1'b0;
      unique case (r_state)
         StPrime: begin
            if (w_level >= LW'(START_LVL)) begin
               w_state_nxt = StRun;
            end
         end
         StRun: begin
            if (rd_en) begin
               if (w_level == '0) begin
                  w_underrun  = 1'b1;
                  w_state_nxt = StPrime;
               end else begin
                  w_pop = 1'b1;
               end
            end
         end
         default: w_state_nxt = StPrime;
      endcase
   end

   // Storage is not reset; pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {s_ldata, s_rdata};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + LW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + LW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_valid <= 1'b0;
         r_ldata    <= '0;
         r_rdata    <= '0;
      end else begin
         r_rd_valid <= rd_en;
         if (rd_en) begin
            if (w_pop) begin
               {r_ldata, r_rdata} <= r_mem[r_rd_ptr[AW-1:0]];
            end else begin
               r_ldata <= '0;
               r_rdata <= '0;
            end
         end
      end
   end

   // An underrun in the same cycle as a clear restarts the count at one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_underrun     <= 1'b0;
         r_underrun_cnt <= '0;
      end else if (w_underrun) begin
         r_underrun <= 1'b1;
         if (clr_underrun) begin
            r_underrun_cnt <= 16'd1;
         end else if (r_underrun_cnt != 16'hFFFF) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
         end
      end else if (clr_underrun) begin
         r_underrun     <= 1'b0;
         r_underrun_cnt <= '0;
      end
   end

   assign ldata        = r_ldata;
   assign rdata        = r_rdata;
   assign rd_valid     = r_rd_valid;
   assign level        = w_level;
   assign running      = (r_state == StRun);
   assign underrun     = r_underrun;
   assign underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Bench for i2s_tx_fifo: directed scenarios plus random traffic, checked every cycle against a
// queue-based model of the sample buffer.
module tb_i2s_tx_fifo;

   localparam int unsigned DW        = 24;
   localparam int unsigned DEPTH     = 16;
   localparam int unsigned START_LVL = 8;
   localparam int unsigned LW        = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic [DW-1:0] s_ldata;
   logic [DW-1:0] s_rdata;
   logic          s_valid;
   logic          s_ready;
   logic          rd_en;
   logic [DW-1:0] ldata;
   logic [DW-1:0] rdata;
   logic          rd_valid;
   logic [LW-1:0] level;
   logic          running;
   logic          underrun;
   logic [15:0]   underrun_cnt;
   logic          clr_underrun;

   i2s_tx_fifo #(
      .DW        (DW),
      .DEPTH     (DEPTH),
      .START_LVL (START_LVL)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .s_ldata      (s_ldata),
      .s_rdata      (s_rdata),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .rd_en        (rd_en),
      .ldata        (ldata),
      .rdata        (rdata),
      .rd_valid     (rd_valid),
      .level        (level),
      .running      (running),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt),
      .clr_underrun (clr_underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks;
   int failures;

   // Reference model: a queue of stereo pairs plus playback/underrun bookkeeping.
   logic [2*DW-1:0] m_q [$];
   bit              m_running;
   bit              m_underrun;
   int              m_cnt;
   bit              m_rdv;
   logic [DW-1:0]   m_ld;
   logic [DW-1:0]   m_rd;
   bit              last_wr;
   bit              seen_full;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_running  = 0;
      m_underrun = 0;
      m_cnt      = 0;
      m_rdv      = 0;
      m_ld       = '0;
      m_rd       = '0;
   endtask

   task automatic model_edge(input bit v, input logic [DW-1:0] l, input logic [DW-1:0] r,
                             input bit rd, input bit clr);
      int sz;
      bit wr;
      bit ur;
      sz = m_q.size();
      wr = v && (sz != DEPTH);
      ur = 0;
      m_rdv = rd;
      if (rd) begin
         if (m_running && sz > 0) begin
            {m_ld, m_rd} = m_q.pop_front();
         end else begin
            m_ld = '0;
            m_rd = '0;
            ur   = m_running;
         end
      end
      if (m_running) m_running = !ur;
      else m_running = (sz >= START_LVL);
      if (wr) m_q.push_back({l, r});
      if (ur) begin
         m_underrun = 1;
         m_cnt      = clr ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
      end else if (clr) begin
         m_underrun = 0;
         m_cnt      = 0;
      end
      last_wr = wr;
   endtask

   task automatic check_all();
      check("rd_valid", 64'(rd_valid), 64'(m_rdv));
      check("ldata", 64'(ldata), 64'(m_ld));
      check("rdata", 64'(rdata), 64'(m_rd));
      check("level", 64'(level), 64'(m_q.size()));
      check("s_ready", 64'(s_ready), 64'(m_q.size() != DEPTH));
      check("running", 64'(running), 64'(m_running));
      check("underrun", 64'(underrun), 64'(m_underrun));
      check("underrun_cnt", 64'(underrun_cnt), 64'(m_cnt));
   endtask

   // Drive at the falling edge, let the rising edge act, compare at the next falling edge.
   task automatic step(input bit v, input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input bit rd, input bit clr);
      s_valid      = v;
      s_ldata      = l;
      s_rdata      = r;
      rd_en        = rd;
      clr_underrun = clr;
      @(posedge clk);
      model_edge(v, l, r, rd, clr);
      @(negedge clk);
      check_all();
      if (m_q.size() == DEPTH && !s_ready && level == LW'(DEPTH)) seen_full = 1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0);
   endtask

   task automatic wait_running();
      for (int i = 0; i < 8 && !m_running; i++) step(0, '0, '0, 0, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && m_q.size() > 0; i++) step(0, '0, '0, 1, 0);
   endtask

   task automatic write_n(input int n, input logic [DW-1:0] lbase, input logic [DW-1:0] rbase);
      for (int i = 0; i < n; i++) step(1, lbase + DW'(i), rbase + DW'(i), 0, 0);
   endtask

   initial begin
      int idx;
      checks       = 0;
      failures     = 0;
      seen_full    = 0;
      rst          = 1'b1;
      s_valid      = 1'b0;
      s_ldata      = '0;
      s_rdata      = '0;
      rd_en        = 1'b0;
      clr_underrun = 1'b0;
      model_reset();
      #3;
      check_all();
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // Prime: a read during priming returns silence without popping.
      write_n(7, 24'h000001, 24'h100001);
      step(0, '0, '0, 1, 0);
      check("prime_zero_l", 64'(ldata), 64'h0);
      step(1, 24'h000008, 24'h100008, 0, 0);
      wait_running();
      check("prime_running", 64'(running), 64'h1);
      step(0, '0, '0, 1, 0);
      check("prime_first_l", 64'(ldata), 64'h000001);
      check("prime_first_r", 64'(rdata), 64'h100001);
      check("prime_level", 64'(level), 64'd7);

      // Fill: hold s_valid over 20 pairs; reads free space only once full.
      idx = 0;
      for (int c = 0; c < 200 && idx < 20; c++) begin
         step(1, 24'h200000 + DW'(idx), 24'h300000 + DW'(idx), (m_q.size() == DEPTH) && c[0], 0);
         if (last_wr) idx++;
      end
      check("fill_all_accepted", 64'(idx), 64'd20);
      check("fill_saw_full", 64'(seen_full), 64'h1);

      // Underrun: drain, then one more read.
      drain();
      step(0, '0, '0, 1, 0);
      check("ur_flag", 64'(underrun), 64'h1);
      check("ur_cnt", 64'(underrun_cnt), 64'd1);
      check("ur_running", 64'(running), 64'h0);

      // Simultaneous write and pop at level 3, then at empty.
      write_n(8, 24'h400000, 24'h500000);
      wait_running();
      for (int i = 0; i < 5; i++) step(0, '0, '0, 1, 0);
      step(1, 24'h4000AA, 24'h5000AA, 1, 0);
      check("simul_level", 64'(level), 64'd3);
      drain();
      step(1, 24'h4000BB, 24'h5000BB, 1, 0);
      check("empty_wr_rd_level", 64'(level), 64'd1);
      check("empty_wr_rd_cnt", 64'(underrun_cnt), 64'd2);

      // Clear racing an underrun, then a lone clear.
      write_n(7, 24'h600000, 24'h700000);
      wait_running();
      drain();
      step(0, '0, '0, 1, 1);
      check("clr_race_flag", 64'(underrun), 64'h1);
      check("clr_race_cnt", 64'(underrun_cnt), 64'd1);
      step(0, '0, '0, 0, 1);
      check("clr_flag", 64'(underrun), 64'h0);
      check("clr_cnt", 64'(underrun_cnt), 64'd0);

      // Asynchronous reset between edges at level 10.
      write_n(10, 24'h800000, 24'h900000);
      check("pre_rst_level", 64'(level), 64'd10);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 55, DW'($urandom), DW'($urandom),
              $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
